// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, parity modes and the
// parity helper also used by the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int NONE = 0;
  localparam int XOR  = 1;
  localparam int XNOR = 2;

  // Callers zero-extend their data word, so frames up to 32 data bits are supported.
  function automatic logic parity_bit(input logic [31:0] data, input int mode);
    logic p;
    p = ^data;
    if (mode == XNOR)
      p = ~p;
    else if (mode == NONE)
      p = 1'b0;
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle
// (high) level so the receiver does not see a false start bit out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver with a valid/ready output register and per-frame
// error flags. Optional break detection is enabled by UART_RX_BREAK_DET_EN.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_tick,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 break_det,
`endif
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  uart_state_t state_reg, state_next;

  logic                 rxs;
  logic [TW-1:0]        tick_cnt_reg;
  logic [BW-1:0]        bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 perr_reg;

  logic mid_hit, end_hit, last_bit;
  logic tick_clr, shift_en, parity_en, frame_done;
  logic break_hold, deliver;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (rx_serial),
    .dout  (rxs)
  );

  assign mid_hit  = (tick_cnt_reg == TICK_MID);
  assign end_hit  = (tick_cnt_reg == TICK_END);
  assign last_bit = (bit_cnt_reg == BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (rx_tick) begin
      case (state_reg)
        IDLE:    if (!break_hold && !rxs) state_next = START;
        START:   if (mid_hit) state_next = rxs ? IDLE : DATA;
        DATA:    if (end_hit && last_bit) state_next = (PARITY_MODE == NONE) ? STOP : PARITY;
        PARITY:  if (end_hit) state_next = STOP;
        STOP:    if (end_hit) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_reg != IDLE);
    tick_clr   = (state_reg == IDLE) || (state_next != state_reg) || end_hit;
    shift_en   = rx_tick && (state_reg == DATA)   && end_hit;
    parity_en  = rx_tick && (state_reg == PARITY) && end_hit;
    frame_done = rx_tick && (state_reg == STOP)   && end_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      perr_reg     <= 1'b0;
    end else if (rx_tick) begin
      tick_cnt_reg <= tick_clr ? '0 : tick_cnt_reg + 1'b1;
      if (state_reg != DATA)
        bit_cnt_reg <= '0;
      else if (shift_en)
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      // LSB arrives first, so shifting in at the top leaves it at bit 0.
      if (shift_en)
        shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
      if (parity_en)
        perr_reg <= (rxs != parity_bit(32'(shift_reg), PARITY_MODE));
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic par_zero_reg;
  logic break_frame;

  assign break_frame = (shift_reg == '0) && ((PARITY_MODE == NONE) || par_zero_reg) && !rxs;
  assign deliver     = !break_frame;
  assign break_hold  = break_det;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_zero_reg <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      if (parity_en)
        par_zero_reg <= !rxs;
      if (frame_done && break_frame)
        break_det <= 1'b1;
      else if (rx_tick && (state_reg == IDLE) && rxs)
        break_det <= 1'b0;
    end
  end
`else
  assign deliver    = 1'b1;
  assign break_hold = 1'b0;
`endif

  // A completed frame is dropped only when the previous one is still unaccepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (frame_done && deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_reg;
          parity_err <= perr_reg;
          frame_err  <= !rxs;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: rx_tick every clk, OVERSAMPLE=16, XOR parity.
module tb_uart_receiver;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_tick = 1'b1;
  logic       rx_serial = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun_err, busy;
`ifdef UART_RX_BREAK_DET_EN
  logic       break_det;
`endif

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   ov_cnt = 0;

  always #5 clk = ~clk;

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_tick     (rx_tick),
    .rx_serial   (rx_serial),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
`ifdef UART_RX_BREAK_DET_EN
    .break_det   (break_det),
`endif
    .busy        (busy)
  );

  // Pop and compare each frame as the consumer accepts it.
  always @(negedge clk) begin
    if (overrun_err) ov_cnt++;
    if (!reset && rx_valid && rx_ready) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_frame: got data=%02h perr=%0b ferr=%0b, none expected",
                 rx_data, parity_err, frame_err);
      end else begin
        e = sb.pop_front();
        if ({rx_data, parity_err, frame_err} !== {e.data, e.perr, e.ferr}) begin
          bad++;
          $display("FAIL frame: got data=%02h perr=%0b ferr=%0b, want data=%02h perr=%0b ferr=%0b",
                   rx_data, parity_err, frame_err, e.data, e.perr, e.ferr);
        end else begin
          $display("frame ok: data=%02h perr=%0b ferr=%0b", rx_data, parity_err, frame_err);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_serial = bits[i];
      idle(16);
    end
    rx_serial = 1'b1;
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    idle(3);
    @(negedge clk);
    total++;
    if ({rx_data, rx_valid, parity_err, frame_err, overrun_err, busy} !== 13'd0) begin
      bad++;
      $display("FAIL reset_state: got data=%02h v=%0b pe=%0b fe=%0b ov=%0b busy=%0b, want all 0",
               rx_data, rx_valid, parity_err, frame_err, overrun_err, busy);
    end
    reset = 1'b0;
    idle(20);
  endtask

  task automatic test_basic;
    int cnt;
    cnt = 0;
    push(8'hA5, 1'b0, 1'b0);
    fork
      send_frame(8'hA5, ^8'hA5, 1'b1);
      begin
        while (!rx_valid && cnt < 400) begin
          @(negedge clk);
          cnt++;
        end
      end
    join
    total++;
    if (cnt < 165 || cnt > 180) begin
      bad++;
      $display("FAIL latency: got %0d clks to rx_valid, want about 171", cnt);
    end
    idle(16);
  endtask

  task automatic test_parity;
    push(8'h01, 1'b1, 1'b0);
    send_frame(8'h01, 1'b0, 1'b1);
    idle(16);
    push(8'h7E, 1'b0, 1'b0);
    send_frame(8'h7E, ^8'h7E, 1'b1);
    idle(16);
  endtask

  task automatic test_frame_err;
    push(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, ^8'h3C, 1'b0);
    idle(32);
    push(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, ^8'h55, 1'b1);
    idle(16);
  endtask

  task automatic test_overrun;
    rx_ready = 1'b0;
    ov_cnt = 0;
    push(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    idle(20);
    @(negedge clk);
    total++;
    if (rx_data !== 8'h11 || rx_valid !== 1'b1 || ov_cnt != 1) begin
      bad++;
      $display("FAIL overrun_hold: got data=%02h v=%0b pulses=%0d, want data=11 v=1 pulses=1",
               rx_data, rx_valid, ov_cnt);
    end
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h11) begin
      bad++;
      $display("FAIL accept_drop: got v=%0b data=%02h, want v=0 data=11", rx_valid, rx_data);
    end
    idle(16);
  endtask

  task automatic test_glitch;
    logic saw_busy;
    saw_busy = 1'b0;
    rx_serial = 1'b0;
    idle(5);
    rx_serial = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    total++;
    if (saw_busy !== 1'b1 || busy !== 1'b0 || rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL glitch: got saw_busy=%0b busy=%0b v=%0b, want 1 0 0", saw_busy, busy, rx_valid);
    end
    idle(16);
  endtask

  task automatic test_reset_mid_frame;
    rx_serial = 1'b0;
    idle(16);
    rx_serial = 1'b1;
    idle(40);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({rx_data, rx_valid, parity_err, frame_err, overrun_err, busy} !== 13'd0) begin
      bad++;
      $display("FAIL mid_reset: got data=%02h v=%0b pe=%0b fe=%0b ov=%0b busy=%0b, want all 0",
               rx_data, rx_valid, parity_err, frame_err, overrun_err, busy);
    end
    idle(2);
    reset = 1'b0;
    idle(32);
    push(8'h0F, 1'b0, 1'b0);
    send_frame(8'h0F, ^8'h0F, 1'b1);
    idle(16);
  endtask

`ifdef UART_RX_BREAK_DET_EN
  task automatic test_break;
    int cnt;
    rx_serial = 1'b0;
    idle(12 * 16);
    @(negedge clk);
    total++;
    if (break_det !== 1'b1 || rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL break_set: got break_det=%0b v=%0b, want 1 0", break_det, rx_valid);
    end
    @(posedge clk);
    #1;
    rx_serial = 1'b1;
    cnt = 0;
    while (break_det && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    total++;
    if (break_det !== 1'b0) begin
      bad++;
      $display("FAIL break_clear: got break_det=%0b after %0d clks, want 0", break_det, cnt);
    end
    idle(16);
    push(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, ^8'h81, 1'b1);
    idle(16);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_frame_err;
    test_overrun;
    test_glitch;
    test_reset_mid_frame;
`ifdef UART_RX_BREAK_DET_EN
    test_break;
`endif
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d frames outstanding, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
